// File: rtl/booth_acc.sv
// Block accumulator behind the Booth multiplier. It sums LEN signed products and presents each block total on a valid/ready port.
// Optional feature: define BOOTH_ACC_SAT_EN to saturate on overflow instead of wrapping.
module booth_acc #(
  parameter int PW  = 16,
  parameter int AW  = 24,
  parameter int LEN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p_valid,
  output logic          p_ready,
  input  logic [PW-1:0] p_data,
  output logic          acc_valid,
  input  logic          acc_ready,
  output logic [AW-1:0] acc_data,
  output logic          acc_ovf
);

  // The counter only needs to reach LEN-1, because the last product ends the block.
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] acc_data_q, acc_data_d;
  logic          acc_ovf_q, acc_ovf_d;

  logic [AW:0]   sum_ext;
  logic          add_ovf;
  logic [AW-1:0] sum_next;

  always_comb begin
    sum_ext = {sum_q[AW-1], sum_q} + {{(AW + 1 - PW){p_data[PW-1]}}, p_data};
    add_ovf = sum_ext[AW] ^ sum_ext[AW-1];
  end

`ifdef BOOTH_ACC_SAT_EN
  localparam logic [AW-1:0] SUM_MAX = {1'b0, {(AW - 1){1'b1}}};
  localparam logic [AW-1:0] SUM_MIN = {1'b1, {(AW - 1){1'b0}}};

  // The true sign of the sum is bit AW, so it selects which rail to clamp to.
  always_comb begin
    if (add_ovf) sum_next = sum_ext[AW] ? SUM_MIN : SUM_MAX;
    else         sum_next = sum_ext[AW-1:0];
  end
`else
  always_comb begin
    sum_next = sum_ext[AW-1:0];
  end
`endif

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    acc_data_d = acc_data_q;
    acc_ovf_d  = acc_ovf_q;
    p_ready    = 1'b0;
    acc_valid  = 1'b0;
    case (state_q)
      ACCUM: begin
        p_ready = 1'b1;
        if (p_valid) begin
          sum_d = sum_next;
          cnt_d = cnt_q + CW'(1);
          ovf_d = ovf_q | add_ovf;
          if (cnt_q == LAST) begin
            acc_data_d = sum_next;
            acc_ovf_d  = ovf_q | add_ovf;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        acc_valid = 1'b1;
        if (acc_ready) begin
          sum_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      sum_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      acc_data_q <= '0;
      acc_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      acc_data_q <= acc_data_d;
      acc_ovf_q  <= acc_ovf_d;
    end
  end

  assign acc_data = acc_data_q;
  assign acc_ovf  = acc_ovf_q;

endmodule

// File: tb/tb_booth_acc.sv
// Scoreboard bench for booth_acc. It uses three instances: the defaults, AW=16 for overflow, and LEN=1.
module tb_booth_acc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // instance A: defaults
  logic        a_pv = 1'b0, a_pr, a_av, a_ao, a_ar;
  logic [15:0] a_pd = '0;
  logic [23:0] a_ad;
  logic        a_ar_dir = 1'b1, a_ar_rnd = 1'b1, a_rnd_mode = 1'b0;
  assign a_ar = a_rnd_mode ? a_ar_rnd : a_ar_dir;
  always @(posedge clk) a_ar_rnd <= ($urandom_range(0, 3) != 0);

  // instance B: AW=16
  logic        b_pv = 1'b0, b_pr, b_av, b_ao, b_ar = 1'b1;
  logic [15:0] b_pd = '0;
  logic [15:0] b_ad;

  // instance C: LEN=1
  logic        c_pv = 1'b0, c_pr, c_av, c_ao, c_ar = 1'b1;
  logic [15:0] c_pd = '0;
  logic [23:0] c_ad;

  booth_acc u_a (.clk(clk), .rst_n(rst_n), .p_valid(a_pv), .p_ready(a_pr), .p_data(a_pd),
                 .acc_valid(a_av), .acc_ready(a_ar), .acc_data(a_ad), .acc_ovf(a_ao));
  booth_acc #(.PW(16), .AW(16), .LEN(4)) u_b (.clk(clk), .rst_n(rst_n), .p_valid(b_pv), .p_ready(b_pr),
                 .p_data(b_pd), .acc_valid(b_av), .acc_ready(b_ar), .acc_data(b_ad), .acc_ovf(b_ao));
  booth_acc #(.PW(16), .AW(24), .LEN(1)) u_c (.clk(clk), .rst_n(rst_n), .p_valid(c_pv), .p_ready(c_pr),
                 .p_data(c_pd), .acc_valid(c_av), .acc_ready(c_ar), .acc_data(c_ad), .acc_ovf(c_ao));

  longint a_exp_d[$], b_exp_d[$], c_exp_d[$];
  bit     a_exp_o[$], b_exp_o[$], c_exp_o[$];
  longint a_s = 0, b_s = 0, c_s = 0;
  int     a_n = 0, b_n = 0, c_n = 0;
  bit     a_ov = 0, b_ov = 0, c_ov = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic no_result(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got a result, expected none", nm);
  endtask

  // Reference: exact integer sum, range-checked against an aw-bit signed accumulator.
  function automatic void mdl(input longint p, input int aw, input int len,
                              inout longint s, inout int n, inout bit ov, output bit done);
    longint mx, mn, m, t;
    mx = (longint'(1) <<< (aw - 1)) - 1;
    mn = -mx - 1;
    m  = longint'(1) <<< aw;
    s  = s + p;
    if (s > mx || s < mn) begin
      ov = 1'b1;
`ifdef BOOTH_ACC_SAT_EN
      s = (s > mx) ? mx : mn;
`else
      t = (s - mn) % m;
      if (t < 0) t = t + m;
      s = t + mn;
`endif
    end
    n++;
    done = (n == len);
  endfunction

  task automatic send_a(input longint p);
    int t = 0;
    bit done;
    a_pd = p[15:0];
    a_pv = 1'b1;
    @(negedge clk);
    while (!a_pr && t < 50) begin @(negedge clk); t++; end
    if (!a_pr) chk("a_accept_timeout", 0, 1);
    mdl(p, 24, 4, a_s, a_n, a_ov, done);
    if (done) begin a_exp_d.push_back(a_s); a_exp_o.push_back(a_ov); a_s = 0; a_n = 0; a_ov = 0; end
    @(posedge clk); #1;
    a_pv = 1'b0;
  endtask

  task automatic send_b(input longint p);
    int t = 0;
    bit done;
    b_pd = p[15:0];
    b_pv = 1'b1;
    @(negedge clk);
    while (!b_pr && t < 50) begin @(negedge clk); t++; end
    if (!b_pr) chk("b_accept_timeout", 0, 1);
    mdl(p, 16, 4, b_s, b_n, b_ov, done);
    if (done) begin b_exp_d.push_back(b_s); b_exp_o.push_back(b_ov); b_s = 0; b_n = 0; b_ov = 0; end
    @(posedge clk); #1;
    b_pv = 1'b0;
  endtask

  task automatic send_c(input longint p);
    int t = 0;
    bit done;
    c_pd = p[15:0];
    c_pv = 1'b1;
    @(negedge clk);
    while (!c_pr && t < 50) begin @(negedge clk); t++; end
    if (!c_pr) chk("c_accept_timeout", 0, 1);
    mdl(p, 24, 1, c_s, c_n, c_ov, done);
    if (done) begin c_exp_d.push_back(c_s); c_exp_o.push_back(c_ov); c_s = 0; c_n = 0; c_ov = 0; end
    @(posedge clk); #1;
    c_pv = 1'b0;
  endtask

  function automatic longint rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return longint'($signed(r));
  endfunction

  // Monitors: pop and compare on every output handshake; check hold-stability under backpressure.
  logic        a_hold = 0, b_hold = 0, c_hold = 0;
  logic [23:0] a_prev = '0, c_prev = '0;
  logic [15:0] b_prev = '0;

  always @(negedge clk) begin
    if (rst_n && a_av) begin
      chk("a_pready_in_done", longint'(a_pr), 0);
      if (a_hold) chk("a_data_stable", longint'($signed(a_ad)), longint'($signed(a_prev)));
      if (a_ar) begin
        if (a_exp_d.size() == 0) no_result("a_unexpected");
        else begin
          chk("a_data", longint'($signed(a_ad)), a_exp_d.pop_front());
          chk("a_ovf", longint'(a_ao), longint'(a_exp_o.pop_front()));
        end
      end
    end
    a_hold = rst_n && a_av && !a_ar;
    a_prev = a_ad;
  end

  always @(negedge clk) begin
    if (rst_n && b_av) begin
      chk("b_pready_in_done", longint'(b_pr), 0);
      if (b_hold) chk("b_data_stable", longint'($signed(b_ad)), longint'($signed(b_prev)));
      if (b_ar) begin
        if (b_exp_d.size() == 0) no_result("b_unexpected");
        else begin
          chk("b_data", longint'($signed(b_ad)), b_exp_d.pop_front());
          chk("b_ovf", longint'(b_ao), longint'(b_exp_o.pop_front()));
        end
      end
    end
    b_hold = rst_n && b_av && !b_ar;
    b_prev = b_ad;
  end

  always @(negedge clk) begin
    if (rst_n && c_av) begin
      chk("c_pready_in_done", longint'(c_pr), 0);
      if (c_hold) chk("c_data_stable", longint'($signed(c_ad)), longint'($signed(c_prev)));
      if (c_ar) begin
        if (c_exp_d.size() == 0) no_result("c_unexpected");
        else begin
          chk("c_data", longint'($signed(c_ad)), c_exp_d.pop_front());
          chk("c_ovf", longint'(c_ao), longint'(c_exp_o.pop_front()));
        end
      end
    end
    c_hold = rst_n && c_av && !c_ar;
    c_prev = c_ad;
  end

  initial begin
    #12;
    chk("rst_a_valid", longint'(a_av), 0);
    chk("rst_a_data", longint'(a_ad), 0);
    chk("rst_a_ovf", longint'(a_ao), 0);
    chk("rst_b_valid", longint'(b_av), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_a_pready", longint'(a_pr), 1);

    // back-to-back block with exact latency checks
    send_a(256); send_a(0); send_a(1);
    chk("t1_valid_early", longint'(a_av), 0);
    send_a(300);
    chk("t1_valid_latency", longint'(a_av), 1);
    chk("t1_pready_low", longint'(a_pr), 0);
    @(posedge clk); #1;

    // negative products with idle gaps
    send_a(-520);  repeat (2) @(posedge clk); #1;
    send_a(476);   @(posedge clk); #1;
    send_a(-3010); repeat (3) @(posedge clk); #1;
    send_a(-3424);
    repeat (2) @(posedge clk); #1;

    // output backpressure, then a fresh block
    a_ar_dir = 1'b0;
    send_a(10); send_a(20); send_a(30); send_a(40);
    a_pd = 16'd7;
    a_pv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_held", longint'(a_av), 1);
      chk("bp_pready_low", longint'(a_pr), 0);
    end
    a_ar_dir = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_pready", longint'(a_pr), 1);
    send_a(7); send_a(-1); send_a(2); send_a(3);
    repeat (2) @(posedge clk); #1;

    // overflow on AW=16, followed by a clean block
    for (int i = 0; i < 4; i++) send_b(32767);
    chk("ovf_flag_direct", longint'(b_ao), 1);
    for (int i = 0; i < 4; i++) send_b(1);
    chk("ovf_cleared_next", longint'(b_ao), 0);
    repeat (2) @(posedge clk); #1;

    // reset mid-block
    send_a(100); send_a(200);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", longint'(a_av), 0);
    chk("rst_mid_data", longint'(a_ad), 0);
    chk("rst_mid_ovf", longint'(a_ao), 0);
    a_s = 0; a_n = 0; a_ov = 0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_a(1); send_a(2); send_a(3); send_a(4);
    chk("rst_mid_after", longint'($signed(a_ad)), 10);
    repeat (2) @(posedge clk); #1;

    // reset while holding a result
    a_ar_dir = 1'b0;
    send_a(5); send_a(6); send_a(7); send_a(8);
    chk("rst_done_valid_before", longint'(a_av), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_done_valid_drop", longint'(a_av), 0);
    a_exp_d.delete(); a_exp_o.delete();
    #1 rst_n = 1'b1;
    a_ar_dir = 1'b1;
    @(posedge clk); #1;

    // LEN=1
    send_c(5);
    chk("len1_valid_a", longint'(c_av), 1);
    chk("len1_pready_a", longint'(c_pr), 0);
    @(posedge clk); #1;
    chk("len1_pready_b", longint'(c_pr), 1);
    send_c(-7);
    chk("len1_valid_b", longint'(c_av), 1);
    chk("len1_pready_c", longint'(c_pr), 0);
    @(posedge clk); #1;

    // randomized traffic
    a_rnd_mode = 1'b1;
    for (int blk = 0; blk < 40; blk++) begin
      for (int k = 0; k < 4; k++) begin
        send_a(rnd16());
        if ($urandom_range(0, 2) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
    end
    a_rnd_mode = 1'b0;
    for (int blk = 0; blk < 20; blk++)
      for (int k = 0; k < 4; k++) send_b(rnd16());
    for (int k = 0; k < 10; k++) send_c(rnd16());

    repeat (10) @(posedge clk); #1;
    chk("a_queue_drained", longint'(a_exp_d.size()), 0);
    chk("b_queue_drained", longint'(b_exp_d.size()), 0);
    chk("c_queue_drained", longint'(c_exp_d.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
